// File: rtl/alu_arb_if.sv
// ---------------------------------------------------------------------------
// alu_arb_if
//
// Requester-side bundle for alu_arb. It carries two request channels
// (valid/ready plus ALU operands) and two response channels
// (valid/ready plus captured result and zero flag).
//
// Parameters:
//   W : operand/result width, matching the shared alu32
//
// Modports:
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side (accepts requests, presents responses)
// ---------------------------------------------------------------------------
interface alu_arb_if #(
  parameter int W = 32
);

  // Request channels
  logic         req0_valid;
  logic         req1_valid;
  logic         req0_ready;
  logic         req1_ready;
  logic [W-1:0] req0_srca;
  logic [W-1:0] req1_srca;
  logic [W-1:0] req0_srcb;
  logic [W-1:0] req1_srcb;
  logic [3:0]   req0_ctrl;
  logic [3:0]   req1_ctrl;
  logic [4:0]   req0_shamt;
  logic [4:0]   req1_shamt;

  // Response channels
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic         rsp0_ready;
  logic         rsp1_ready;
  logic [W-1:0] rsp0_data;
  logic [W-1:0] rsp1_data;
  logic         rsp0_zero;
  logic         rsp1_zero;

  modport master (
    output req0_valid, req1_valid,
    output req0_srca,  req1_srca,
    output req0_srcb,  req1_srcb,
    output req0_ctrl,  req1_ctrl,
    output req0_shamt, req1_shamt,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp0_data,  rsp1_data,
    input  rsp0_zero,  rsp1_zero,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_srca,  req1_srca,
    input  req0_srcb,  req1_srcb,
    input  req0_ctrl,  req1_ctrl,
    input  req0_shamt, req1_shamt,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp0_data,  rsp1_data,
    output rsp0_zero,  rsp1_zero,
    input  rsp0_ready, rsp1_ready
  );

endinterface : alu_arb_if

// File: rtl/alu_arb.sv
// ---------------------------------------------------------------------------
// alu_arb
//
// Two-requester arbiter in front of one combinational alu32. Each cycle at
// most one request is routed to the ALU. Its result is captured in a
// single-entry response slot and returned on the owner's response channel
// the following cycle. The slot can drain and refill in the same cycle, so
// one op per cycle is sustained while the consumer keeps rsp_ready high.
//
// Configuration macro:
//   ALU_ARB_RR_EN : defined   -> round-robin tie break (pointer register)
//                   undefined -> fixed priority, req0 wins every tie
//
// Ports:
//   clk         : sole clock, rising edge
//   reset       : asynchronous, active-high; clears all state
//   bus         : alu_arb_if.slave, two request and two response channels
//   alu_srca    : operand A to alu32 (0 when nothing is granted)
//   alu_srcb    : operand B to alu32 (0 when nothing is granted)
//   alu_control : control code to alu32 (0 when nothing is granted)
//   alu_shamt   : shift amount to alu32 (0 when nothing is granted)
//   alu_out     : result from alu32
//   alu_zero    : zero flag from alu32
// ---------------------------------------------------------------------------
module alu_arb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_arb_if.slave     bus,
  output logic [W-1:0] alu_srca,
  output logic [W-1:0] alu_srcb,
  output logic [3:0]   alu_control,
  output logic [4:0]   alu_shamt,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero
);

  // -------------------------------------------------------------------------
  // Response slot state
  // -------------------------------------------------------------------------
  logic         full_q,  full_d;
  logic         owner_q, owner_d;
  logic [W-1:0] data_q,  data_d;
  logic         zero_q,  zero_d;

`ifdef ALU_ARB_RR_EN
  // Index of the most recently granted requester; ties go to the other one.
  logic         ptr_q,   ptr_d;
`endif

  // -------------------------------------------------------------------------
  // Slot availability
  // -------------------------------------------------------------------------
  logic owner_ready;
  logic free;

  // Only the owner's rsp_ready can drain the slot; the other one is ignored.
  assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  assign free        = !full_q || owner_ready;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic grant_vld;
  logic grant_idx;

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (free) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
`ifdef ALU_ARB_RR_EN
        grant_idx = ~ptr_q;
`else
        grant_idx = 1'b0;
`endif
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  // A grant is only ever issued to a valid requester while the slot is free,
  // so ready doubles as the accept strobe.
  assign bus.req0_ready = grant_vld && !grant_idx;
  assign bus.req1_ready = grant_vld &&  grant_idx;

  // -------------------------------------------------------------------------
  // ALU operand mux
  // -------------------------------------------------------------------------
  always_comb begin
    alu_srca    = '0;
    alu_srcb    = '0;
    alu_control = '0;
    alu_shamt   = '0;
    if (grant_vld) begin
      if (grant_idx) begin
        alu_srca    = bus.req1_srca;
        alu_srcb    = bus.req1_srcb;
        alu_control = bus.req1_ctrl;
        alu_shamt   = bus.req1_shamt;
      end else begin
        alu_srca    = bus.req0_srca;
        alu_srcb    = bus.req0_srcb;
        alu_control = bus.req0_ctrl;
        alu_shamt   = bus.req0_shamt;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Slot next state
  // -------------------------------------------------------------------------
  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    data_d  = data_q;
    zero_d  = zero_q;
    if (grant_vld) begin
      // Accept (possibly in the same cycle as a drain): load the new result.
      full_d  = 1'b1;
      owner_d = grant_idx;
      data_d  = alu_out;
      zero_d  = alu_zero;
    end else if (full_q && owner_ready) begin
      // Drain only: data and zero keep their last values.
      full_d  = 1'b0;
    end
  end

`ifdef ALU_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = grant_idx;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its _d value from before the clock edge.
  // NOTE: data and zero are reset as well as full, so rsp*_data/rsp*_zero
  // read 0 out of reset instead of X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q  <= 1'b0;
      owner_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Pointer resets to 1 so that req0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Response outputs: both ports show the slot, only the owner sees valid
  // -------------------------------------------------------------------------
  assign bus.rsp0_valid = full_q && !owner_q;
  assign bus.rsp1_valid = full_q &&  owner_q;
  assign bus.rsp0_data  = data_q;
  assign bus.rsp1_data  = data_q;
  assign bus.rsp0_zero  = zero_q;
  assign bus.rsp1_zero  = zero_q;

endmodule : alu_arb

// File: doc/alu_arb.md
# alu_arb

Two-requester arbiter sharing one combinational `alu32` in the calculator datapath. It accepts operation requests from two independent masters, such as the keypad-driven calculator sequencer and the CPU execute stage. Each cycle it routes at most one request to the ALU and captures the result in a single-entry response register. The result is returned on that requester's response channel with valid/ready handshaking.

## Interface
- `W`, 32, operand/result width; must match `alu32`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req0_valid`, `req1_valid` in 1: request present.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle.
- `req0_srca`, `req1_srca` in W: operand A.
- `req0_srcb`, `req1_srcb` in W: operand B.
- `req0_ctrl`, `req1_ctrl` in 4: ALU control code, passed through unmodified.
- `req0_shamt`, `req1_shamt` in 5: shift amount, passed through unmodified.
- `rsp0_valid`, `rsp1_valid` out 1: result available for that requester.
- `rsp0_ready`, `rsp1_ready` in 1: requester consumes result.
- `rsp0_data`, `rsp1_data` out W: captured `aluout`.
- `rsp0_zero`, `rsp1_zero` out 1: captured `zero`.
- `alu_srca`, `alu_srcb` out W: to `alu32`.
- `alu_control` out 4: to `alu32`.
- `alu_shamt` out 5: to `alu32`.
- `alu_out` in W: from `alu32`.
- `alu_zero` in 1: from `alu32`.

## Operation
- Response slot: one entry holding `{owner, data, zero}` plus `full`.
  - `rspN_valid = full && owner==N`.
  - `rspN_data` and `rspN_zero` come from the slot.
  - Both ports carry slot contents; only the owner's valid is asserted.
- `free = !full || (owner's rsp_ready)`, so the slot supports same-cycle drain and refill.
- Arbitration runs only when `free`:
  - One valid requester: it is granted.
  - Both valid: winner is chosen by policy (see Configuration).
- `reqN_ready = free && grant==N`. At most one ready is high per cycle.
  - Ready may depend on valid.
  - Requesters must not make valid depend on ready.
- ALU muxing:
  - With a grant, `alu_*` equal the granted requester's `srca/srcb/ctrl/shamt`.
  - With no grant, all `alu_*` are driven to 0.
- On accept (`valid && ready`): slot loads `owner=N`, `data=alu_out`, `zero=alu_zero`, and sets `full`.
- On drain without accept: `full` clears; data and zero hold their last values.
- Requester obligation: hold request fields stable while `valid && !ready`. The bench asserts this.

## Timing
- Reset values:
  - All `reqN_ready` = 0 (no valid present).
  - All `rspN_valid` = 0.
  - `rspN_data` = 0; `rspN_zero` = 0.
  - `alu_*` = 0.
  - `full` = 0; owner = 0; RR pointer = 1, so req0 has first priority.
- Latency: result appears on `rspN_*` the cycle after acceptance.
- Throughput: 1 op/cycle sustained when the consumer holds `rsp_ready` = 1.
- Backpressure: owner holds `rsp_ready` = 0 while full → both `reqN_ready` = 0. Slot contents hold unchanged.
- Non-owner `rsp_ready` is ignored.
- Reset asserted mid-operation discards any pending response immediately; it is never delivered.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin.
  - On a grant to N, the pointer is set to N.
  - On a tie, the requester that is not the pointer wins.
  - No starvation: a continuously-valid requester wins within 2 accepts.
- Not defined: fixed priority. req0 always wins ties; there is no pointer register.

## Test plan
- ALU stub for all scenarios: `alu_out = alu_srca + alu_srcb`; `alu_zero = (alu_out == 0)`.
- Single op: req0 `srca=0xC`, `srcb=0x5`, `ctrl=4'b1000`, `rsp0_ready=1`. Expect:
  - `req0_ready` = 1 in cycle 0.
  - `rsp0_valid` = 1, `rsp0_data` = 0x11, `rsp0_zero` = 0 in cycle 1.
  - `rsp1_valid` = 0 throughout.
- Zero flag: req1 `srca=0xFFFFFFFF`, `srcb=0x1`. Expect `rsp1_data` = 0, `rsp1_zero` = 1 the next cycle.
- Tie, RR: both valid for 4 cycles with ready held at 1. Expect grants 0,1,0,1.
  - Without `ALU_ARB_RR_EN`: grants 0,0,0,0.
- Backpressure: slot full for req0 with `rsp0_ready=0` for 3 cycles while req1 is valid. Expect:
  - `req1_ready` = 0 for those 3 cycles.
  - `rsp0_data` stable.
  - When `rsp0_ready` = 1, req1 is accepted the same cycle and `rsp1_valid` = 1 the next cycle.
- Idle muxing: no valid for 2 cycles. Expect `alu_srca`, `alu_srcb`, `alu_control`, `alu_shamt` all = 0.
- Reset mid-op: assert `reset` with the slot full and `rsp0_ready=0`. Expect `rsp0_valid` = 0 asynchronously, and after release the next tie grants req0.
